aes_key_sched: RTL and testbench
================================

# aes_key_sched

Parametrised AES key-schedule engine. It expands a 128/192/256-bit cipher key into the full round-key sequence and streams the keys out one 128-bit round key at a time over a valid/ready handshake. A compile-time option adds an on-chip round-key store so the sequence can also be streamed in reverse (decryption) order. It sits between the key-load interface and the round datapath, and replaces the single-round, AES-128-only key update block.

## Interface
- `KEY_BITS`, default 128: cipher key length. Legal values are 128, 192 and 256; any other value is an elaboration error. Nk = KEY_BITS/32 and Nr = Nk+6.
- `clk`  in  1: clock, rising edge.
- `rst_n`  in  1: the block has one clock; reset is asynchronous and active-low.
- `key_valid`  in  1: `key_in`/`key_rev` valid.
- `key_ready`  out  1: high only in IDLE.
- `key_in`  in  KEY_BITS: cipher key; `key_in[KEY_BITS-1 -: 32]` is w[0].
- `key_rev`  in  1: request reverse order. Sampled at load; only honoured with `AES_KS_STORE_EN`.
- `abort`  in  1: synchronous abandon of the current expansion.
- `rk_valid`  out  1: `rk_data` holds a round key.
- `rk_ready`  in  1: consumer accepts the round key.
- `rk_data`  out  128: round key; `[127:96]` = w[4r], `[31:0]` = w[4r+3].
- `rk_idx`  out  4: round index r, 0..Nr.
- `rk_last`  out  1: final key of the sequence (r=Nr forward, r=0 reverse).
- `busy`  out  1: not IDLE.

## Operation
- Word recurrence, for i ≥ Nk: w[i] = w[i-Nk] ^ t, with t = w[i-1].
  - If i mod Nk = 0: t = SubWord(RotWord(t)) ^ {Rcon[i/Nk], 24'h0}.
  - Else if Nk = 8 and i mod Nk = 4: t = SubWord(t).
  - For i < Nk: w[i] = key word i.
- Rcon[1..10] = 01,02,04,08,10,20,40,80,1b,36.
- Total words = 4(Nr+1): 44, 52 or 60.
- Datapath:
  - One 32-bit word is produced per GEN cycle.
  - An Nk-word sliding window holds w[i-Nk..i-1].
  - A 4-word staging register assembles each round key.
- States:
  - IDLE: `key_ready`=1. On `key_valid` it loads the key, captures `key_rev`, clears i and r, and goes to GEN.
  - GEN: writes one word per cycle. After the 4th word of a round key it goes to OUT (forward) or stays in GEN (reverse, until all words are stored).
  - OUT: `rk_valid`=1. On `rk_ready` it goes to GEN, or to IDLE if `rk_last`.
  - RPLY (store only): streams stored keys r = Nr down to 0, one per accepted handshake. Exits to IDLE after r=0.
- `rk_data`, `rk_idx` and `rk_last` are stable while `rk_valid` is high and `rk_ready` is low. GEN stalls during OUT; the window is not disturbed.
- `abort`: in any state, goes to IDLE on the next edge. Clears `rk_valid`; no `rk_last` is issued. `abort` has priority over a simultaneous handshake.
- `key_valid` outside IDLE is ignored; `key_ready` is low there.
- Reset (including mid-expansion) returns to IDLE; the round-key store contents need not be cleared.
- Reset values: `key_ready`=1; `rk_valid`, `rk_last`, `busy` = 0; `rk_data`=0; `rk_idx`=0.

## Timing
- Let E0 be the edge where `key_valid && key_ready` is sampled.
- Forward order:
  - RK0 words are written at E1..E4; `rk_valid` is high after E4.
  - Each round key appears 4 edges after the previous one is accepted, so the sequence is 5 cycles per key with `rk_ready` held high.
  - With `rk_ready` always high, the last key (r=Nr) is accepted at edge E0 + 5(Nr+1): 55, 65 or 75.
- Reverse order:
  - All words are generated first, at E1..E(4(Nr+1)).
  - RK Nr is valid after E(4(Nr+1)), i.e. 44/52/60.
  - After that, one key per cycle while `rk_ready` is high.
- `key_ready` returns high the cycle after the `rk_last` handshake.

## Configuration
- `AES_KS_STORE_EN` defined:
  - Adds a (Nr+1)×128 round-key store, written in GEN, plus the RPLY state.
  - `key_rev`=1 selects reverse order.
- Undefined:
  - No store and no RPLY state.
  - `key_rev` is ignored; output is always forward order with Nr+1 keys.

## Structure
- Package `aes_ks_pkg` holds:
  - the SBOX[256] constant;
  - RCON[1..10];
  - functions `nk_of(KEY_BITS)` and `nr_of(KEY_BITS)`;
  - the state enum.
- Sub-module `aes_sbox_word`: combinational 32-bit SubWord (4 SBOX lookups). Instantiated once and shared by both SubWord cases.

## Test plan
- 128-bit forward, key 2b7e151628aed2a6abf7158809cf4f3c, `rk_ready`=1:
  - RK0 = key, valid after E4.
  - RK1 = a0fafe1788542cb123a339392a6c7605.
  - RK10 = d014f9a8c9ee2589e13f0cc8b6630ca6 with `rk_last`; accepted at E55.
- 192-bit, key 8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b:
  - 13 keys.
  - RK12 = e98ba06f448c773c8ecc720401002202 with `rk_last`.
- 256-bit, key 603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4:
  - 15 keys.
  - RK14 = fe4890d1e6188d0b046df344706c631e.
- Backpressure: `rk_ready` randomly low for 128-bit.
  - Outputs are stable while stalled.
  - Same 11 keys as the first scenario.
  - `key_valid` pulses during the run are ignored.
- Abort and reset:
  - `abort` in GEN at RK3: IDLE next edge, `rk_valid`=0, no `rk_last`.
  - `rst_n` low mid-OUT: all outputs at reset values immediately.
  - Reload afterwards: the correct sequence follows.
- With `AES_KS_STORE_EN`, `key_rev`=1, 128-bit key:
  - RK10 = d014f9a8... valid after E44.
  - Then RK9..RK0, one per cycle.
  - RK0 = key, with `rk_last`.

Source files
------------

// File: rtl/aes_ks_pkg.sv
// aes_ks_pkg: shared constants, helpers and state type for the AES key schedule.
// Holds the AES S-box, the round constants and the Nk/Nr helpers.
package aes_ks_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_GEN,
        ST_OUT,
        ST_RPLY
    } ks_state_e;

    localparam logic [7:0] RCON [1:10] = '{
        8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
    };

    localparam logic [7:0] SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    function automatic int unsigned nk_of(input int unsigned key_bits);
        return key_bits / 32;
    endfunction

    function automatic int unsigned nr_of(input int unsigned key_bits);
        return key_bits / 32 + 6;
    endfunction

    // Round constant lookup; indices outside 1..10 yield zero.
    function automatic logic [7:0] rcon_of(input logic [3:0] n);
        rcon_of = 8'h00;
        for (int unsigned k = 1; k <= 10; k++) begin
            if (n == 4'(k)) rcon_of = RCON[k];
        end
    endfunction

endpackage

// File: rtl/aes_key_sched_sbox.sv
// aes_sbox_word: combinational SubWord, four parallel S-box lookups.
module aes_sbox_word
    import aes_ks_pkg::*;
(
    input  logic [31:0] word,
    output logic [31:0] sub
);

    assign sub[31:24] = SBOX[word[31:24]];
    assign sub[23:16] = SBOX[word[23:16]];
    assign sub[15:8]  = SBOX[word[15:8]];
    assign sub[7:0]   = SBOX[word[7:0]];

endmodule

// File: rtl/aes_key_sched.sv
// aes_key_sched: AES-128/192/256 key expansion, one word per GEN cycle,
// round keys streamed over a valid/ready handshake.
// Optional macro AES_KS_STORE_EN adds a round-key store and reverse replay.
module aes_key_sched
    import aes_ks_pkg::*;
#(
    parameter int unsigned KEY_BITS = 128
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                key_valid,
    output logic                key_ready,
    input  logic [KEY_BITS-1:0] key_in,
    input  logic                key_rev,
    input  logic                abort,
    output logic                rk_valid,
    input  logic                rk_ready,
    output logic [127:0]        rk_data,
    output logic [3:0]          rk_idx,
    output logic                rk_last,
    output logic                busy
);

    localparam int unsigned NK    = nk_of(KEY_BITS);
    localparam int unsigned NR    = nr_of(KEY_BITS);
    localparam int unsigned TOTAL = 4 * (NR + 1);

    if (KEY_BITS != 128 && KEY_BITS != 192 && KEY_BITS != 256) begin : g_bad_key_bits
        $error("aes_key_sched: KEY_BITS must be 128, 192 or 256");
    end

    ks_state_e    state, state_n;
    logic [31:0]  win [NK];      // win[0] = w[i-Nk] ... win[NK-1] = w[i-1]
    logic [31:0]  stage [3];     // first three words of the key being assembled
    logic [5:0]   wi;            // word index i
    logic [2:0]   wm;            // i mod Nk
    logic [3:0]   rci;           // i / Nk
    logic [3:0]   rnd;           // next round key to complete
    logic         rk_last_q;
    logic         rev_q;
    logic [31:0]  t_word, sub_in, sub_out, new_word;
    logic [127:0] rk_next;
    logic         load, gen, last_word;

    assign key_ready = (state == ST_IDLE);
    assign busy      = (state != ST_IDLE);
    assign rk_valid  = (state == ST_OUT) || (state == ST_RPLY);
    assign rk_last   = rk_last_q && rk_valid;

    assign load      = (state == ST_IDLE) && key_valid && !abort;
    assign gen       = (state == ST_GEN) && !abort;
    assign last_word = (wi == 6'(TOTAL - 1));
    assign rk_next   = {stage[0], stage[1], stage[2], new_word};

    aes_sbox_word u_sbox (
        .word (sub_in),
        .sub  (sub_out)
    );

    // Word recurrence: the first Nk passes recirculate the key words so the
    // window ends up holding w[0..Nk-1] when generation proper begins.
    always_comb begin
        t_word   = win[NK-1];
        sub_in   = (wm == '0) ? {t_word[23:0], t_word[31:24]} : t_word;
        new_word = win[0];
        if (wi >= 6'(NK)) begin
            if (wm == '0)
                new_word = win[0] ^ sub_out ^ {rcon_of(rci), 24'h0};
            else if (NK == 8 && wm == 3'd4)
                new_word = win[0] ^ sub_out;
            else
                new_word = win[0] ^ t_word;
        end
    end

`ifdef AES_KS_STORE_EN
    logic [127:0] store [NR+1];
    logic         rk_hs;

    assign rk_hs = rk_valid && rk_ready && !abort;

    // Direction of the current expansion, captured at load
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)    rev_q <= 1'b0;
        else if (load) rev_q <= key_rev;
    end

    // Round-key store, written as each key completes
    always_ff @(posedge clk) begin
        if (gen && wi[1:0] == 2'd3) store[rnd] <= rk_next;
    end
`else
    logic unused_key_rev;

    assign unused_key_rev = key_rev;
    assign rev_q          = 1'b0;
`endif

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_n;
    end

    // Next-state logic; abort overrides every transition
    always_comb begin
        state_n = state;
        case (state)
            ST_IDLE: if (key_valid) state_n = ST_GEN;
            ST_GEN: begin
                if (wi[1:0] == 2'd3) begin
                    if (!rev_q)         state_n = ST_OUT;
                    else if (last_word) state_n = ST_RPLY;
                end
            end
            ST_OUT:  if (rk_ready) state_n = rk_last_q ? ST_IDLE : ST_GEN;
`ifdef AES_KS_STORE_EN
            ST_RPLY: if (rk_ready && rk_last_q) state_n = ST_IDLE;
`endif
            default: state_n = ST_IDLE;
        endcase
        if (abort) state_n = ST_IDLE;
    end

    // Window, counters, staging and output key registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned k = 0; k < NK; k++) win[k] <= '0;
            for (int unsigned k = 0; k < 3; k++) stage[k] <= '0;
            wi        <= '0;
            wm        <= '0;
            rci       <= '0;
            rnd       <= '0;
            rk_data   <= '0;
            rk_idx    <= '0;
            rk_last_q <= 1'b0;
        end else if (load) begin
            for (int unsigned k = 0; k < NK; k++) win[k] <= key_in[KEY_BITS-1-32*k -: 32];
            wi  <= '0;
            wm  <= '0;
            rci <= '0;
            rnd <= '0;
        end else if (gen) begin
            for (int unsigned k = 0; k < NK - 1; k++) win[k] <= win[k+1];
            win[NK-1] <= new_word;
            wi        <= wi + 6'd1;
            if (wm == 3'(NK - 1)) begin
                wm  <= '0;
                rci <= rci + 4'd1;
            end else begin
                wm  <= wm + 3'd1;
            end
            case (wi[1:0])
                2'd0:    stage[0] <= new_word;
                2'd1:    stage[1] <= new_word;
                2'd2:    stage[2] <= new_word;
                default: begin
                    rk_data   <= rk_next;
                    rk_idx    <= rnd;
                    rk_last_q <= !rev_q && (rnd == 4'(NR));
                    rnd       <= rnd + 4'd1;
                end
            endcase
        end
`ifdef AES_KS_STORE_EN
        else if (state == ST_RPLY && rk_hs && !rk_last_q) begin
            rk_data   <= store[rk_idx - 4'd1];
            rk_idx    <= rk_idx - 4'd1;
            rk_last_q <= (rk_idx == 4'd1);
        end
`endif
    end

endmodule

// File: tb/tb_aes_key_sched.sv
// tb_aes_key_sched: self-checking bench for aes_key_sched (128/192/256 instances).
// Reference model computes the S-box from GF(2^8) arithmetic and expands keys
// straight from the word recurrence; reverse order expected only with AES_KS_STORE_EN.
module tb_aes_key_sched;

    typedef struct {
        logic [127:0] d;
        logic [3:0]   idx;
        logic         last;
    } rk_t;

    localparam logic [255:0] K128 = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
    localparam logic [255:0] K192 = {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 64'h0};
    localparam logic [255:0] K256 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         key_valid_a [3];
    logic         key_ready_a [3];
    logic [255:0] key_bus;
    logic         key_rev, abort, rk_ready;
    logic         rk_valid_a [3];
    logic [127:0] rk_data_a [3];
    logic [3:0]   rk_idx_a [3];
    logic         rk_last_a [3];
    logic         busy_a [3];

    int  total = 0, bad = 0;
    int  cyc = 0, e0 = 0, sel = 0, first_k = -1, last_edge = -1;
    bit  chk_en = 0, bp = 0, ready_force = 1, first_seen = 0;
    rk_t exp_q [$];
    logic [7:0] sb [256];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    aes_key_sched #(.KEY_BITS(128)) u_k128 (
        .clk(clk), .rst_n(rst_n), .key_valid(key_valid_a[0]), .key_ready(key_ready_a[0]),
        .key_in(key_bus[255:128]), .key_rev(key_rev), .abort(abort), .rk_valid(rk_valid_a[0]),
        .rk_ready(rk_ready), .rk_data(rk_data_a[0]), .rk_idx(rk_idx_a[0]), .rk_last(rk_last_a[0]),
        .busy(busy_a[0]));
    aes_key_sched #(.KEY_BITS(192)) u_k192 (
        .clk(clk), .rst_n(rst_n), .key_valid(key_valid_a[1]), .key_ready(key_ready_a[1]),
        .key_in(key_bus[255:64]), .key_rev(key_rev), .abort(abort), .rk_valid(rk_valid_a[1]),
        .rk_ready(rk_ready), .rk_data(rk_data_a[1]), .rk_idx(rk_idx_a[1]), .rk_last(rk_last_a[1]),
        .busy(busy_a[1]));
    aes_key_sched #(.KEY_BITS(256)) u_k256 (
        .clk(clk), .rst_n(rst_n), .key_valid(key_valid_a[2]), .key_ready(key_ready_a[2]),
        .key_in(key_bus), .key_rev(key_rev), .abort(abort), .rk_valid(rk_valid_a[2]),
        .rk_ready(rk_ready), .rk_data(rk_data_a[2]), .rk_idx(rk_idx_a[2]), .rk_last(rk_last_a[2]),
        .busy(busy_a[2]));

    // ---------------- reference model ----------------
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] x = a;
        for (int k = 0; k < 8; k++) begin
            if (b[k]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
        return (b << n) | (b >> (8 - n));
    endfunction

    function automatic logic [7:0] sbox_calc(input logic [7:0] a);
        logic [7:0] inv = 8'h01;
        for (int k = 0; k < 254; k++) inv = gmul(inv, a);
        return inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    endfunction

    function automatic logic [7:0] rcon_m(input int n);
        logic [7:0] r = 8'h01;
        for (int k = 1; k < n; k++) r = gmul(r, 8'h02);
        return r;
    endfunction

    function automatic logic [31:0] subw(input logic [31:0] t);
        return {sb[t[31:24]], sb[t[23:16]], sb[t[15:8]], sb[t[7:0]]};
    endfunction

    task automatic build_exp(input int kb, input logic [255:0] key, input bit rev);
        logic [31:0] w [60];
        logic [31:0] t;
        rk_t e;
        int nk = kb / 32;
        int nr = nk + 6;
        exp_q.delete();
        for (int i = 0; i < 4 * (nr + 1); i++) begin
            if (i < nk) w[i] = key[255 - 32 * i -: 32];
            else begin
                t = w[i-1];
                if (i % nk == 0) t = subw({t[23:0], t[31:24]}) ^ {rcon_m(i / nk), 24'h0};
                else if (nk == 8 && i % nk == 4) t = subw(t);
                w[i] = w[i-nk] ^ t;
            end
        end
        for (int r = 0; r <= nr; r++) begin
            int rr = rev ? nr - r : r;
            e.d    = {w[4*rr], w[4*rr+1], w[4*rr+2], w[4*rr+3]};
            e.idx  = 4'(rr);
            e.last = (r == nr);
            exp_q.push_back(e);
        end
    endtask

    task automatic chk(input string nm, input logic [127:0] got, input logic [127:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, got, want);
        end
    endtask

    // ---------------- compare process ----------------
    always @(negedge clk) begin
        if (rst_n && chk_en && rk_valid_a[sel]) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL extra_key sel=%0d: got %h idx=%0d, none expected", sel, rk_data_a[sel], rk_idx_a[sel]);
            end else begin
                if (rk_data_a[sel] !== exp_q[0].d || rk_idx_a[sel] !== exp_q[0].idx || rk_last_a[sel] !== exp_q[0].last) begin
                    bad++;
                    $display("FAIL rk_key sel=%0d: got %h idx=%0d last=%b want %h idx=%0d last=%b", sel,
                             rk_data_a[sel], rk_idx_a[sel], rk_last_a[sel], exp_q[0].d, exp_q[0].idx, exp_q[0].last);
                end
                if (!first_seen) begin
                    first_seen = 1;
                    first_k    = cyc - e0;
                end
                if (rk_ready) begin
                    if (exp_q[0].last) last_edge = cyc - e0 + 1;
                    void'(exp_q.pop_front());
                end
            end
        end
    end

    // rk_ready driver: constant or random backpressure
    initial begin
        rk_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            rk_ready = bp ? ($urandom_range(0, 3) != 0) : ready_force;
        end
    end

    // ---------------- scenario tasks ----------------
    task automatic load(input int s, input logic [255:0] key, input bit rev);
        sel        = s;
        first_seen = 0;
        last_edge  = -1;
        @(negedge clk);
        chk("key_ready_idle", key_ready_a[s], 1'b1);
        key_bus        = key;
        key_rev        = rev;
        key_valid_a[s] = 1'b1;
        @(posedge clk);
        #1;
        key_valid_a[s] = 1'b0;
        e0             = cyc;
        chk_en         = 1'b1;
    endtask

    task automatic run(input int s, input int kb, input logic [255:0] key, input bit rev,
                       input bit bpr, input bit tm);
        int  n = 0;
        int  nr = kb / 32 + 6;
        bit  re;
`ifdef AES_KS_STORE_EN
        re = rev;
`else
        re = 1'b0;
`endif
        build_exp(kb, key, re);
        bp          = bpr;
        ready_force = 1'b1;
        load(s, key, rev);
        while (exp_q.size() != 0 && n < 4000) begin
            @(posedge clk);
            #1;
            n++;
            if (bpr) begin
                key_valid_a[s] = (n == 10 || n == 30);
                if (n == 10 || n == 30) key_bus = {$urandom, $urandom, $urandom, $urandom,
                                                   $urandom, $urandom, $urandom, $urandom};
            end
        end
        key_valid_a[s] = 1'b0;
        chk("seq_done", 128'(exp_q.size()), 128'd0);
        @(negedge clk);
        chk("key_ready_after_last", key_ready_a[s], 1'b1);
        chk("busy_after_last", busy_a[s], 1'b0);
        chk_en = 1'b0;
        bp     = 1'b0;
        if (tm) begin
            if (re) begin
                chk("first_valid_edge", 128'(first_k), 128'(4 * (nr + 1)));
                chk("last_accept_edge", 128'(last_edge), 128'(4 * (nr + 1) + nr + 1));
            end else begin
                chk("first_valid_edge", 128'(first_k), 128'd4);
                chk("last_accept_edge", 128'(last_edge), 128'(5 * (nr + 1)));
            end
        end
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int n;
        bit seen;
        for (int k = 0; k < 3; k++) key_valid_a[k] = 1'b0;
        key_bus = '0;
        key_rev = 1'b0;
        abort   = 1'b0;
        rst_n   = 1'b1;
        for (int v = 0; v < 256; v++) sb[v] = sbox_calc(8'(v));

        #2 rst_n = 1'b0;
        #1;
        chk("rst_key_ready", key_ready_a[0], 1'b1);
        chk("rst_rk_valid", rk_valid_a[0], 1'b0);
        chk("rst_rk_last", rk_last_a[0], 1'b0);
        chk("rst_busy", busy_a[0], 1'b0);
        chk("rst_rk_data", rk_data_a[0], 128'h0);
        chk("rst_rk_idx", rk_idx_a[0], 4'h0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // Pin the model against published expansions
        build_exp(128, K128, 0);
        chk("model_rk0", exp_q[0].d, K128[255:128]);
        chk("model_rk1", exp_q[1].d, 128'ha0fafe1788542cb123a339392a6c7605);
        chk("model_rk10", exp_q[10].d, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
        build_exp(192, K192, 0);
        chk("model_192_count", 128'(exp_q.size()), 128'd13);
        chk("model_192_rk12", exp_q[12].d, 128'he98ba06f448c773c8ecc720401002202);
        build_exp(256, K256, 0);
        chk("model_256_count", 128'(exp_q.size()), 128'd15);
        chk("model_256_rk14", exp_q[14].d, 128'hfe4890d1e6188d0b046df344706c631e);

        // Forward, rk_ready held high, with timing
        run(0, 128, K128, 0, 0, 1);
        run(1, 192, K192, 0, 0, 1);
        run(2, 256, K256, 0, 0, 1);

        // Backpressure with ignored key_valid pulses
        run(0, 128, K128, 0, 1, 0);

        // Random keys, random backpressure
        for (int s = 0; s < 3; s++)
            run(s, 128 + 64 * s, {$urandom, $urandom, $urandom, $urandom,
                                  $urandom, $urandom, $urandom, $urandom}, 0, 1, 0);

        // Abort while generating RK3
        build_exp(128, K128, 0);
        ready_force = 1'b1;
        load(0, K128, 0);
        n = 0;
        while (exp_q.size() > 8 && n < 200) begin
            @(posedge clk);
            n++;
        end
        #1;
        chk_en = 1'b0;
        @(posedge clk);
        #1 abort = 1'b1;
        @(posedge clk);
        #1 abort = 1'b0;
        @(negedge clk);
        chk("abort_rk_valid", rk_valid_a[0], 1'b0);
        chk("abort_key_ready", key_ready_a[0], 1'b1);
        chk("abort_busy", busy_a[0], 1'b0);
        seen = 0;
        repeat (10) begin
            @(negedge clk);
            seen = seen | rk_valid_a[0] | rk_last_a[0];
        end
        chk("abort_quiet", seen, 1'b0);
        exp_q.delete();

        // Reset while a key is stalled in OUT
        build_exp(128, K128, 0);
        load(0, K128, 0);
        n = 0;
        while (exp_q.size() > 6 && n < 200) begin
            @(posedge clk);
            n++;
        end
        ready_force = 1'b0;
        n = 0;
        while (!rk_valid_a[0] && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("stall_reached", rk_valid_a[0], 1'b1);
        repeat (2) @(negedge clk);
        #2;
        chk_en = 1'b0;
        rst_n  = 1'b0;
        #1;
        chk("midrst_key_ready", key_ready_a[0], 1'b1);
        chk("midrst_rk_valid", rk_valid_a[0], 1'b0);
        chk("midrst_rk_last", rk_last_a[0], 1'b0);
        chk("midrst_busy", busy_a[0], 1'b0);
        chk("midrst_rk_data", rk_data_a[0], 128'h0);
        chk("midrst_rk_idx", rk_idx_a[0], 4'h0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        exp_q.delete();
        ready_force = 1'b1;
        run(0, 128, K128, 0, 0, 1);

        // Reverse request (forward when the store is not built in)
        run(0, 128, K128, 1, 0, 1);
        run(2, 256, {$urandom, $urandom, $urandom, $urandom,
                     $urandom, $urandom, $urandom, $urandom}, 1, 1, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
